mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, physical memory address width; DATA_W, default 16, word width; MAX_WAIT, default 3, number of consecutive fetch losses before fetch is forced to win.
REQ-002 Port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-003 Port reset, input, 1, asynchronous, active-low reset (asserted at 0).
REQ-004 Port if_req / if_addr, input, 1 / 16, instruction-fetch read request and its word address.
REQ-005 Port if_gnt / if_rvalid / if_rdata, output, 1 / 1 / 16, fetch grant pulse, fetch read-data-valid pulse, and fetch read data.
REQ-006 Port dm_req / dm_we / dm_addr / dm_wdata, input, 1 / 1 / 16 / 16, data request, write enable (1 = SW, 0 = LW), word address, and write data.
REQ-007 Port dm_gnt / dm_rvalid / dm_rdata, output, 1 / 1 / 16, data grant pulse, data read-data-valid pulse, and data read data.
REQ-008 Port mem_en / mem_we / mem_addr / mem_wdata, output, 1 / 1 / ADDR_W / DATA_W, command to the single-port synchronous RAM.
REQ-009 Port mem_rdata, input, DATA_W, RAM read data, valid in the cycle after a read command (mem_en=1, mem_we=0).
REQ-010 Port addr_err, output, 1, one-cycle pulse when a granted access is out of range.
REQ-011 Port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-012 The arbiter SHALL implement three states: IDLE, ACCESS and RESP.
REQ-013 In IDLE or RESP with any request present, the arbiter SHALL choose a winner, register the winner's address, we and wdata, and go to ACCESS; with no request present it SHALL go to (or stay in) IDLE.
REQ-014 Priority: dm SHALL win over if, except that if SHALL win when wait_cnt equals MAX_WAIT.
REQ-015 wait_cnt SHALL increment, saturating at MAX_WAIT, on each decision where if_req=1 and dm wins; it SHALL clear to 0 when if is granted.
REQ-016 In ACCESS the arbiter SHALL, for exactly one cycle:
- assert the winner's gnt;
- drive mem_en=1, mem_we, mem_addr (the registered address's low ADDR_W bits) and mem_wdata;
- then go to RESP.
REQ-017 In RESP, for a read, the arbiter SHALL register mem_rdata into the winner's rdata and pulse the winner's rvalid for one cycle; a write SHALL produce no rvalid.
REQ-018 Latency from request to grant SHALL be: req sampled in cycle N, gnt in cycle N+1, rvalid in cycle N+2. Peak throughput SHALL be one access per 2 cycles.
REQ-019 Requesters SHALL hold req, addr, we and wdata stable until gnt and drop req in the cycle after gnt. A req withdrawn before the decision cycle SHALL be ignored; values are captured only at the decision.
REQ-020 If the registered address bits [15:ADDR_W] are nonzero, ACCESS SHALL still pulse gnt, but SHALL keep mem_en=0 and pulse addr_err. A read SHALL then return rdata=0 with rvalid in RESP; a write SHALL be dropped.
REQ-021 if_rdata and dm_rdata SHALL hold their last value until the next rvalid for that port.
REQ-022 If both requests arrive in the same cycle, they SHALL be served back-to-back: winner gnt at N+1, loser gnt at N+3.

Reset
REQ-023 While reset=0, the arbiter SHALL set state=IDLE and wait_cnt=0, and drive all outputs (gnt, rvalid, rdata, mem_*, addr_err, busy) to 0.
REQ-024 Reset mid-transaction SHALL abort the transaction with no rvalid. After release, pending requests SHALL be re-arbitrated from IDLE.

Structure
REQ-025 The state encoding (IDLE, ACCESS, RESP) and the port-select constants (PORT_IF, PORT_DM) SHALL live in a shared package.
REQ-026 The arbiter SHALL be a single module with one sub-module, arb_priority_sel, a combinational winner select from (if_req, dm_req, wait_cnt == MAX_WAIT).

Verification
REQ-027 Single fetch: if_req=1 with if_addr=5 and RAM[5]=16'h1234 -> if_gnt at N+1 with mem_addr=5, then if_rvalid and if_rdata=16'h1234 at N+2.
REQ-028 Single store: dm_req=1, dm_we=1, dm_addr=8'h20, dm_wdata=16'h00FF -> dm_gnt with mem_we=1 at N+1, no dm_rvalid, and RAM[32]=16'h00FF.
REQ-029 Collision and starvation: both requests held continuously (MAX_WAIT=3) -> grants go dm, dm, dm, if, dm, ...
REQ-030 Out of range: dm_addr=16'h0100, read -> mem_en stays 0, addr_err pulses at N+1, and dm_rvalid=1 with dm_rdata=0 at N+2.
REQ-031 Reset asserted during RESP of a fetch -> no if_rvalid, all outputs 0, and a subsequent if_req is granted 1 cycle after reset release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM state encoding
// and requester-select constants.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_sel_t;

  localparam int unsigned REQ_ADDR_W = 16;
  localparam int unsigned REQ_DATA_W = 16;

endpackage

// File: rtl/mem_port_arbiter_priority_sel.sv
// Combinational winner select: data port has priority unless fetch is starved.
module arb_priority_sel
  import mem_port_arbiter_pkg::*;
(
  input  logic      if_req,
  input  logic      dm_req,
  input  logic      if_starved,
  output logic      any_req,
  output port_sel_t winner
);

  always_comb begin
    any_req = if_req | dm_req;
    winner  = (dm_req && !(if_req && if_starved)) ? PORT_DM : PORT_IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-port synchronous RAM.
// One access per two cycles: decide -> ACCESS (grant + RAM command) -> RESP (read data).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [REQ_ADDR_W-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [REQ_DATA_W-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [REQ_ADDR_W-1:0] dm_addr,
  input  logic [REQ_DATA_W-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [REQ_DATA_W-1:0] dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  addr_err,
  output logic                  busy
);

  localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  arb_state_t              state, state_next;
  port_sel_t               port_q, winner;
  logic                    any_req, if_starved, decide, out_of_range, rd_resp;
  logic                    we_q;
  logic [REQ_ADDR_W-1:0]   addr_q;
  logic [REQ_DATA_W-1:0]   wdata_q, if_hold, dm_hold, resp_data;
  logic [WAIT_W-1:0]       wait_cnt;

  assign if_starved   = (wait_cnt == WAIT_W'(MAX_WAIT));
  assign decide       = (state == IDLE) || (state == RESP);
  assign out_of_range = ((addr_q >> ADDR_W) != '0);
  assign rd_resp      = (state == RESP) && !we_q;
  assign resp_data    = out_of_range ? '0 : REQ_DATA_W'(mem_rdata);

  arb_priority_sel u_sel (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .if_starved (if_starved),
    .any_req    (any_req),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, RESP: state_next = any_req ? ACCESS : IDLE;
      ACCESS:     state_next = RESP;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_q   <= PORT_IF;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_cnt <= '0;
      if_hold  <= '0;
      dm_hold  <= '0;
    end else begin
      if (decide && any_req) begin
        port_q <= winner;
        if (winner == PORT_DM) begin
          we_q    <= dm_we;
          addr_q  <= dm_addr;
          wdata_q <= dm_wdata;
        end else begin
          we_q    <= 1'b0;
          addr_q  <= if_addr;
          wdata_q <= '0;
        end
        if (winner == PORT_IF)          wait_cnt <= '0;
        else if (if_req && !if_starved) wait_cnt <= wait_cnt + 1'b1;
      end
      // Read data is forwarded combinationally in RESP and held here afterwards.
      if (rd_resp && port_q == PORT_IF) if_hold <= resp_data;
      if (rd_resp && port_q == PORT_DM) dm_hold <= resp_data;
    end
  end

  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    if_rdata  = if_hold;
    dm_rdata  = dm_hold;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    addr_err  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      ACCESS: begin
        if_gnt    = (port_q == PORT_IF);
        dm_gnt    = (port_q == PORT_DM);
        addr_err  = out_of_range;
        mem_en    = !out_of_range;
        mem_we    = we_q && !out_of_range;
        mem_addr  = addr_q[ADDR_W-1:0];
        mem_wdata = DATA_W'(wdata_q);
      end
      RESP: begin
        if (!we_q) begin
          if (port_q == PORT_IF) begin
            if_rvalid = 1'b1;
            if_rdata  = resp_data;
          end else begin
            dm_rvalid = 1'b1;
            dm_rdata  = resp_data;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
